// File: rtl/rf_pkg.sv
// Shared types and helpers for the reg_file_bank register file.
package rf_pkg;

  localparam int unsigned MaxDw = 512;
  localparam int unsigned MaxNb = MaxDw / 8;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Byte-lane merge at the widest supported width; callers zero-extend and slice.
  function automatic logic [MaxDw-1:0] be_merge(input logic [MaxDw-1:0] old_val,
                                                input logic [MaxDw-1:0] new_val,
                                                input logic [MaxNb-1:0] be);
    logic [MaxDw-1:0] res;
    res = old_val;
    for (int unsigned k = 0; k < MaxNb; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_bank_if.sv
// Write/read/clear bus between a requester and reg_file_bank.
interface reg_file_bank_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 2
);

  logic                W_En;
  logic [AW-1:0]       W_Addr;
  logic [DW-1:0]       W_Data;
  logic [DW/8-1:0]     W_Be;
  logic                W_Rdy;
  logic [NR*AW-1:0]    R_Addr;
  logic [NR*DW-1:0]    R_Data;
  logic                Clear;
  logic                Busy;

  modport master (
    output W_En, W_Addr, W_Data, W_Be, R_Addr, Clear,
    input  W_Rdy, R_Data, Busy
  );

  modport slave (
    input  W_En, W_Addr, W_Data, W_Be, R_Addr, Clear,
    output W_Rdy, R_Data, Busy
  );

endinterface

// File: rtl/rf_clear_ctrl.sv
// Sequential clear engine: walks ptr over every entry once per Clear request.
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  output logic          Busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      RF_IDLE: begin
        if (Clear) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        // DEPTH is a power of two, so the increment wraps back to 0 on the last entry.
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  assign Busy     = (state_q == RF_CLEAR);
  assign clr_en   = Busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_bank.sv
// Parametrised register file: byte-enable writes, NR registered read ports with
// write/clear bypass, and a sequential clear engine.
module reg_file_bank
  import rf_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned NR       = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic            Clk,
  input logic            Reset,
  reg_file_bank_if.slave bus
);

  logic             busy;
  logic             clr_en;
  logic [AW-1:0]    clr_addr;
  logic [DW-1:0]    mem_q [DEPTH];
  logic             wr_en;
  logic [DW-1:0]    wr_old;
  logic [DW-1:0]    wr_merged;
  logic [MaxDw-1:0] wr_merged_full;
  logic             unused_merge_hi;

  rf_clear_ctrl #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_clear_ctrl (
    .Clk     (Clk),
    .Reset   (Reset),
    .Clear   (bus.Clear),
    .Busy    (busy),
    .clr_en  (clr_en),
    .clr_addr(clr_addr)
  );

  assign bus.Busy  = busy;
  assign bus.W_Rdy = !busy;

  assign wr_en = bus.W_En && !busy && (bus.W_Be != '0) &&
                 !(ZERO_REG && (bus.W_Addr == '0));

  // One merged value feeds both the array write and every read-port bypass.
  assign wr_old          = mem_q[bus.W_Addr];
  assign wr_merged_full  = be_merge(MaxDw'(wr_old), MaxDw'(bus.W_Data), MaxNb'(bus.W_Be));
  assign wr_merged       = wr_merged_full[DW-1:0];
  assign unused_merge_hi = ^wr_merged_full[MaxDw-1:DW];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_en) begin
      mem_q[bus.W_Addr] <= wr_merged;
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [AW-1:0] raddr;
    logic [DW-1:0] data_q;

    assign raddr = bus.R_Addr[p*AW +: AW];

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        data_q <= '0;
      end else if (ZERO_REG && (raddr == '0)) begin
        data_q <= '0;
      end else if (clr_en && (raddr == clr_addr)) begin
        data_q <= '0;
      end else if (wr_en && (raddr == bus.W_Addr)) begin
        data_q <= wr_merged;
      end else begin
        data_q <= mem_q[raddr];
      end
    end

    assign bus.R_Data[p*DW +: DW] = data_q;
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Scoreboard bench for reg_file_bank in two configurations (32x32x2 and 64x8x4).
module tb_reg_file_bank;

  localparam int KD = 0;  // read data of a port
  localparam int KB = 1;  // Busy
  localparam int KR = 2;  // W_Rdy

  typedef struct {
    int          due;
    int          kind;
    int          port;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];

  reg_file_bank_if #(.DW(32), .AW(5), .NR(2)) bus_a ();
  reg_file_bank_if #(.DW(64), .AW(3), .NR(4)) bus_b ();

  reg_file_bank #(.DW(32), .DEPTH(32), .NR(2), .ZERO_REG(1'b1)) dut_a (
    .Clk  (clk),
    .Reset(rst_a),
    .bus  (bus_a)
  );

  reg_file_bank #(.DW(64), .DEPTH(8), .NR(4), .ZERO_REG(1'b0)) dut_b (
    .Clk  (clk),
    .Reset(rst_b),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] b64(input bit b);
    return b ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] act_a(input int kind, input int port);
    logic [63:0] r;
    case (kind)
      KD:      r = {32'h0, bus_a.R_Data[port*32 +: 32]};
      KB:      r = {63'h0, bus_a.Busy};
      default: r = {63'h0, bus_a.W_Rdy};
    endcase
    return r;
  endfunction

  function automatic logic [63:0] act_b(input int kind, input int port);
    logic [63:0] r;
    case (kind)
      KD:      r = bus_b.R_Data[port*64 +: 64];
      KB:      r = {63'h0, bus_b.Busy};
      default: r = {63'h0, bus_b.W_Rdy};
    endcase
    return r;
  endfunction

  // Monitor: compare every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      e   = qa.pop_front();
      act = act_a(e.kind, e.port);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s (A port %0d cyc %0d): got %h, expected %h",
                 e.name, e.port, cyc, act, e.val);
      end
    end
    while (qb.size() > 0 && qb[0].due <= cyc) begin
      e   = qb.pop_front();
      act = act_b(e.kind, e.port);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s (B port %0d cyc %0d): got %h, expected %h",
                 e.name, e.port, cyc, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ea(input int due, input int kind, input int port, input logic [63:0] val,
                    input string name);
    qa.push_back('{due, kind, port, val, name});
  endtask

  task automatic eb(input int due, input int kind, input int port, input logic [63:0] val,
                    input string name);
    qb.push_back('{due, kind, port, val, name});
  endtask

  task automatic ra(input int p, input int addr);
    bus_a.R_Addr[p*5 +: 5] = 5'(addr);
  endtask

  task automatic rb(input int p, input int addr);
    bus_b.R_Addr[p*3 +: 3] = 3'(addr);
  endtask

  task automatic wa(input logic en, input int addr, input logic [31:0] d, input logic [3:0] be);
    bus_a.W_En   = en;
    bus_a.W_Addr = 5'(addr);
    bus_a.W_Data = d;
    bus_a.W_Be   = be;
  endtask

  task automatic wb(input logic en, input int addr, input logic [63:0] d, input logic [7:0] be);
    bus_b.W_En   = en;
    bus_b.W_Addr = 3'(addr);
    bus_b.W_Data = d;
    bus_b.W_Be   = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000ns, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    wa(1'b0, 0, 32'h0, 4'h0);
    wb(1'b0, 0, 64'h0, 8'h0);
    bus_a.R_Addr = '0;
    bus_b.R_Addr = '0;
    bus_a.Clear  = 1'b0;
    bus_b.Clear  = 1'b0;
    repeat (3) step();

    // Reset state
    ea(cyc, KB, 0, 64'd0, "rst_busy");
    ea(cyc, KR, 0, 64'd1, "rst_wrdy");
    ea(cyc, KD, 0, 64'd0, "rst_rd");
    ea(cyc, KD, 1, 64'd0, "rst_rd");
    eb(cyc, KB, 0, 64'd0, "b_rst_busy");
    eb(cyc, KR, 0, 64'd1, "b_rst_wrdy");
    for (int p = 0; p < 4; p++) eb(cyc, KD, p, 64'd0, "b_rst_rd");
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;

    ra(0, 7); ra(1, 31);
    ea(cyc + 1, KD, 0, 64'd0, "rd_after_rst");
    ea(cyc + 1, KD, 1, 64'd0, "rd_after_rst");
    step();

    // Byte-enable writes and bypass
    wa(1'b1, 5, 32'h1111_1234, 4'hF); ra(0, 5); ra(1, 6);
    ea(cyc + 1, KD, 0, 64'h1111_1234, "wr_full_bypass");
    step();
    wa(1'b1, 5, 32'hFFFF_FFFF, 4'b0010); ra(0, 6); ra(1, 5);
    ea(cyc + 1, KD, 1, 64'h1111_FF34, "be_merge_bypass");
    step();
    wa(1'b0, 0, 32'h0, 4'h0); ra(0, 5); ra(1, 5);
    ea(cyc + 1, KD, 0, 64'h1111_FF34, "be_merge_array");
    ea(cyc + 1, KD, 1, 64'h1111_FF34, "be_merge_array");
    step();
    wa(1'b1, 9, 32'h0000_0607, 4'hF); ra(0, 9); ra(1, 9);
    ea(cyc + 1, KD, 0, 64'h607, "dual_bypass");
    ea(cyc + 1, KD, 1, 64'h607, "dual_bypass");
    step();
    wa(1'b1, 0, 32'hFFFF_FFFF, 4'hF); ra(0, 0); ra(1, 0);
    ea(cyc + 1, KD, 0, 64'd0, "zero_reg_bypass");
    ea(cyc + 1, KD, 1, 64'd0, "zero_reg_bypass");
    step();
    wa(1'b1, 9, 32'hAAAA_AAAA, 4'h0); ra(0, 0); ra(1, 9);
    ea(cyc + 1, KD, 0, 64'd0, "zero_reg_array");
    ea(cyc + 1, KD, 1, 64'h607, "be_zero_dropped");
    step();
    wa(1'b0, 0, 32'h0, 4'h0);
    ea(cyc + 1, KD, 1, 64'h607, "be_zero_array");
    step();

    // Fill with addr+1, then clear while watching entries 4 and 31
    for (int a = 0; a < 32; a++) begin
      wa(1'b1, a, 32'(a + 1), 4'hF);
      step();
    end
    wa(1'b0, 0, 32'h0, 4'h0); ra(0, 0); ra(1, 31);
    ea(cyc + 1, KD, 0, 64'd0, "fill_r0");
    ea(cyc + 1, KD, 1, 64'h20, "fill_r31");
    step();
    ra(0, 4);
    for (int i = 0; i < 35; i++) begin
      bus_a.Clear = (i == 0) || (i == 10);
      if (i == 3) wa(1'b1, 31, 32'hDEAD_BEEF, 4'hF);
      else wa(1'b0, 0, 32'h0, 4'h0);
      ea(cyc + 1, KB, 0, b64(i <= 31), "clr_busy");
      ea(cyc + 1, KR, 0, b64(i > 31), "clr_wrdy");
      ea(cyc + 1, KD, 0, (i + 1 <= 5) ? 64'd5 : 64'd0, "clr_r4");
      ea(cyc + 1, KD, 1, (i + 1 <= 32) ? 64'h20 : 64'd0, "clr_r31");
      step();
    end
    bus_a.Clear = 1'b0;
    ra(0, 1); ra(1, 31);
    ea(cyc + 1, KD, 0, 64'd0, "post_clr_r1");
    ea(cyc + 1, KD, 1, 64'd0, "post_clr_r31");
    step();
    wa(1'b1, 2, 32'h55, 4'hF); ra(0, 2);
    ea(cyc, KR, 0, 64'd1, "post_clr_wrdy");
    ea(cyc + 1, KD, 0, 64'h55, "post_clr_wr");
    step();

    // Reset in the middle of a clear
    wa(1'b1, 3, 32'h33, 4'hF);
    step();
    wa(1'b1, 20, 32'h44, 4'hF);
    step();
    wa(1'b0, 0, 32'h0, 4'h0); ra(0, 20); ra(1, 3);
    for (int i = 0; i < 9; i++) begin
      bus_a.Clear = (i == 0);
      ea(cyc + 1, KB, 0, 64'd1, "rclr_busy");
      ea(cyc + 1, KD, 0, 64'h44, "rclr_r20");
      ea(cyc + 1, KD, 1, (i + 1 <= 4) ? 64'h33 : 64'd0, "rclr_r3");
      step();
    end
    step();
    rst_a = 1'b1;
    ea(cyc, KB, 0, 64'd0, "rst_mid_busy");
    ea(cyc, KR, 0, 64'd1, "rst_mid_wrdy");
    ea(cyc, KD, 0, 64'd0, "rst_mid_rd");
    ea(cyc, KD, 1, 64'd0, "rst_mid_rd");
    step();
    step();
    rst_a = 1'b0;
    wa(1'b1, 3, 32'h0BAD_F00D, 4'hF); ra(0, 3); ra(1, 20);
    ea(cyc, KR, 0, 64'd1, "post_rst_wrdy");
    ea(cyc + 1, KD, 0, 64'h0BAD_F00D, "post_rst_wr_bypass");
    ea(cyc + 1, KD, 1, 64'd0, "post_rst_r20");
    step();
    wa(1'b0, 0, 32'h0, 4'h0);
    for (int a = 0; a < 16; a++) begin
      ra(0, a); ra(1, a + 16);
      ea(cyc + 1, KD, 0, (a == 3) ? 64'h0BAD_F00D : 64'd0, "post_rst_sweep");
      ea(cyc + 1, KD, 1, 64'd0, "post_rst_sweep");
      step();
    end

    // Configuration B: 64-bit, 8 entries, 4 ports, entry 0 writable
    wb(1'b1, 0, 64'h0123_4567_89AB_CDEF, 8'hFF); rb(0, 0); rb(1, 1); rb(2, 2); rb(3, 3);
    eb(cyc + 1, KD, 0, 64'h0123_4567_89AB_CDEF, "b_addr0_bypass");
    for (int p = 1; p < 4; p++) eb(cyc + 1, KD, p, 64'd0, "b_empty");
    step();
    wb(1'b1, 7, 64'hFEDC_BA98_7654_3210, 8'b1000_0001); rb(0, 0); rb(1, 7); rb(2, 0); rb(3, 5);
    eb(cyc + 1, KD, 0, 64'h0123_4567_89AB_CDEF, "b_addr0_array");
    eb(cyc + 1, KD, 1, 64'hFE00_0000_0000_0010, "b_be_bypass");
    eb(cyc + 1, KD, 2, 64'h0123_4567_89AB_CDEF, "b_same_addr");
    eb(cyc + 1, KD, 3, 64'd0, "b_empty5");
    step();
    wb(1'b1, 5, 64'h1111_2222_3333_4444, 8'hFF); rb(0, 7); rb(1, 0); rb(2, 6); rb(3, 7);
    eb(cyc + 1, KD, 0, 64'hFE00_0000_0000_0010, "b_be_array");
    eb(cyc + 1, KD, 1, 64'h0123_4567_89AB_CDEF, "b_p1_addr0");
    eb(cyc + 1, KD, 2, 64'd0, "b_empty6");
    eb(cyc + 1, KD, 3, 64'hFE00_0000_0000_0010, "b_p3_addr7");
    step();
    wb(1'b0, 0, 64'h0, 8'h0); rb(0, 5); rb(1, 7); rb(2, 0); rb(3, 1);
    eb(cyc + 1, KD, 0, 64'h1111_2222_3333_4444, "b_p0_addr5");
    eb(cyc + 1, KD, 1, 64'hFE00_0000_0000_0010, "b_p1_addr7");
    eb(cyc + 1, KD, 2, 64'h0123_4567_89AB_CDEF, "b_p2_addr0");
    eb(cyc + 1, KD, 3, 64'd0, "b_p3_addr1");
    step();
    rb(0, 7); rb(1, 0); rb(2, 5); rb(3, 3);
    for (int i = 0; i < 11; i++) begin
      bus_b.Clear = (i == 0);
      eb(cyc + 1, KB, 0, b64(i <= 7), "b_clr_busy");
      eb(cyc + 1, KR, 0, b64(i > 7), "b_clr_wrdy");
      eb(cyc + 1, KD, 0, (i + 1 <= 8) ? 64'hFE00_0000_0000_0010 : 64'd0, "b_clr_r7");
      eb(cyc + 1, KD, 1, (i + 1 <= 1) ? 64'h0123_4567_89AB_CDEF : 64'd0, "b_clr_r0");
      eb(cyc + 1, KD, 2, (i + 1 <= 6) ? 64'h1111_2222_3333_4444 : 64'd0, "b_clr_r5");
      eb(cyc + 1, KD, 3, 64'd0, "b_clr_r3");
      step();
    end
    bus_b.Clear = 1'b0;
    repeat (2) step();

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
# reg_file_bank

Parametrised multi-read-port register file, the next generation of the team's 32×32 MIPS-style register file. Adds configurable width, depth and read-port count, byte-enable writes, registered reads with write-to-read bypass, and a sequential clear engine that can zero the array without asserting reset. It sits between the decode stage and the datapath, and also behind the board-level LED/switch debug top.

## Interface
Parameters:
- DW, default 32: data width in bits; must be a multiple of 8.
- DEPTH, default 32: number of entries; must be a power of two and at least 2.
- AW, default $clog2(DEPTH): address width.
- NR, default 2: number of read ports, 1..4.
- ZERO_REG, default 1: when 1, entry 0 always reads 0 and writes to it are dropped.

Ports:
- Clk, in, 1: single clock; all state updates on the rising edge.
- Reset, in, 1: asynchronous, active-high; zeroes every entry, every output register and the FSM.
- W_En, in, 1: write request.
- W_Addr, in, AW: write address.
- W_Data, in, DW: write data.
- W_Be, in, DW/8: byte enables; bit k selects W_Data[8k+7:8k].
- W_Rdy, out, 1: write accepted this cycle. Equals !Busy.
- R_Addr, in, NR*AW: packed read addresses; port p uses bits [p*AW +: AW].
- R_Data, out, NR*DW: packed registered read data; port p uses bits [p*DW +: DW].
- Clear, in, 1: single-cycle request to start a sequential clear.
- Busy, out, 1: sequential clear in progress.

## Operation
- A write occurs when W_En && W_Rdy && (W_Be != 0). Only the enabled bytes change. If ZERO_REG=1 and W_Addr=0, the write is dropped.
- Each read port registers its data every cycle: R_Data_p <= mem[R_Addr_p].
- Bypass: if a write occurs in the same cycle to R_Addr_p, R_Data_p receives the merged value (new bytes where W_Be is set, old bytes elsewhere). Reads never return stale data.
- ZERO_REG=1: any read of address 0 returns 0, regardless of any write in that cycle.
- Clear FSM, two states: IDLE and CLEAR.
  - IDLE → CLEAR when Clear=1. The internal pointer ptr is loaded with 0.
  - In CLEAR, mem[ptr] <= 0 and ptr increments by 1 each cycle.
  - CLEAR → IDLE on the cycle that clears ptr = DEPTH-1; ptr wraps to 0.
  - Busy = (state == CLEAR).
- While Busy, W_Rdy=0 and writes are dropped; the requester must hold the write and retry. Reads continue normally: entries already cleared read 0, the rest read their old contents. A read of ptr in the same cycle it is cleared returns 0 (bypass of the clear).
- Clear asserted while Busy is ignored; the pointer does not restart.
- Reset asserted mid-clear aborts the clear immediately: all entries become 0, state becomes IDLE, Busy=0.
- Multiple read ports may read the same address simultaneously. There is no port priority.

## Timing
- Reset values: R_Data=0, Busy=0, W_Rdy=1, all entries 0, ptr=0.
- Read latency: 1 cycle. An address presented at edge n produces data after edge n+1, including bypassed data.
- Write latency: data is visible through bypass at the same edge, and through the array from edge n+1 onward.
- Clear: Clear sampled high at edge n → Busy high after edge n. Entry k is zeroed at edge n+1+k. Busy falls after edge n+DEPTH.
- The clear sequence takes exactly DEPTH cycles. W_Rdy is low for exactly those DEPTH cycles.
- Asynchronous Reset deassertion must meet recovery time to Clk. The block does not synchronise Reset.

## Structure
- Package rf_pkg holds:
  - the FSM state typedef (RF_IDLE, RF_CLEAR);
  - the function be_merge(old, new, be) used by both the array write and the bypass path.
- One sub-module, rf_clear_ctrl, holds the FSM and ptr and outputs Busy, clr_en and clr_addr. The top instantiates it together with the storage array and NR read-port generate blocks.

## Test plan
- Reset with DW=32, DEPTH=32, NR=2 → R_Data=0, Busy=0, W_Rdy=1; reading any address returns 0.
- Write 0x1111_1234 to addr 5 with W_Be=4'hF, then write 0xFFFF_FFFF to addr 5 with W_Be=4'b0010; read port 1 at addr 5 → 0x1111_FF34 one cycle later.
- In the same cycle, write 0x0000_0607 to addr 9 while both ports read addr 9 → both ports show 0x0000_0607 after the next edge. Write 0xFFFF_FFFF to addr 0 → port 0 reads 0.
- Fill all 32 entries with value = addr+1, pulse Clear, and read addr 31 every cycle:
  - Busy is high for exactly 32 cycles;
  - addr 31 reads 0x20 until the cycle it is cleared, then 0;
  - a write issued during Busy is dropped (W_Rdy=0).
- Assert Reset at clear cycle 10 → Busy drops immediately and all entries read 0. A subsequent write to addr 3 is accepted in the first cycle after Reset is released.
- Parameter sweep with DW=64, DEPTH=8, NR=4, ZERO_REG=0 → addr 0 is writable; all four ports read independently; clear completes in 8 cycles.
